systolic_seq_ctrl: RTL and testbench

- Sequencer for an N x N array of MAC processing elements.
- On start, it issues one diagonally skewed operand schedule over K elements. The same schedule drives the row (A) lanes and column (B) lanes: per-lane element index, waiting strobe and a finished pulse.
- It stalls on PE readiness, waits for results to drain through the array, then pulses done.
- It sits between the operand buffers, which are addressed by lane_idx, and the edge PEs of the array.

---
 rtl/systolic_seq_ctrl_if.sv | 31 +++
 rtl/systolic_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_if.sv
// Bundle of signals between the sequencer, its requester and the array edge.
// The requester side (start/k_len) and the PE readiness inputs are grouped on
// the master modport. The sequencer itself uses the slave modport.
interface systolic_seq_ctrl_if #(
   parameter int N     = 4,
   parameter int K_MAX = 16,
   parameter int IDX_W = $clog2(K_MAX),
   parameter int KL_W  = $clog2(K_MAX + 1)
);
   logic                 start;
   logic [KL_W-1:0]      k_len;
   logic                 busy;
   logic                 done;
   logic                 start_err;
   logic [N-1:0]         a_ready;
   logic [N-1:0]         b_ready;
   logic [N-1:0]         lane_waiting;
   logic [N-1:0]         lane_finished;
   logic [N*IDX_W-1:0]   lane_idx;
   logic [15:0]          stall_cnt;

   modport master (
      output start, k_len, a_ready, b_ready,
      input  busy, done, start_err, lane_waiting, lane_finished, lane_idx, stall_cnt
   );

   modport slave (
      input  start, k_len, a_ready, b_ready,
      output busy, done, start_err, lane_waiting, lane_finished, lane_idx, stall_cnt
   );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Operand sequencer for an N x N systolic MAC array.
// A start latches a reduction length K and walks a wave counter w through
// 0..K+N-1. Each wave presents a diagonally skewed element index on every
// lane, and the wave only advances when every presenting lane sees both of
// its edge PEs ready. After the last wave, a fixed drain delay lets results
// flush through the array before a one-cycle done pulse.
// All lane outputs are registered, so ready never reaches them
// combinationally.
module systolic_seq_ctrl #(
   parameter int N         = 4,
   parameter int K_MAX     = 16,
   parameter int DRAIN_CYC = 8,
   parameter int IDX_W     = $clog2(K_MAX),
   parameter int KL_W      = $clog2(K_MAX + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   systolic_seq_ctrl_if.slave   bus
);

   // Wave counter is sized to hold K_MAX+N-1 without wrapping.
   localparam int W_W  = $clog2(K_MAX + N + 1);
   localparam int DC_W = $clog2(DRAIN_CYC + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef struct packed {
      logic [N-1:0]       waiting;
      logic [N-1:0]       finished;
      logic [N*IDX_W-1:0] idx;
   } lanes_t;

   logic [1:0]      state_q,     state_d;
   logic [W_W-1:0]  w_q,         w_d;
   logic [KL_W-1:0] k_q,         k_d;
   logic [DC_W-1:0] drain_q,     drain_d;
   logic [15:0]     stall_q,     stall_d;
   lanes_t          lanes_q,     lanes_d;
   logic            busy_q,      busy_d;
   logic            done_q,      done_d;
   logic            start_err_q, start_err_d;

   logic            k_len_ok;
   logic            accept;
   logic            last_wave;

   // Lane outputs for wave w of a length-k schedule: lane i carries element
   // w-i while that index is in range, and flags end-of-stream one wave later.
   function automatic lanes_t wave_lanes(input logic [W_W-1:0] w, input logic [KL_W-1:0] k);
      lanes_t l;
      l = '0;
      for (int i = 0; i < N; i++) begin
         if ((int'(w) >= i) && (int'(w) < i + int'(k))) begin
            l.waiting[i]              = 1'b1;
            l.idx[i*IDX_W +: IDX_W]   = IDX_W'(int'(w) - i);
         end else if (int'(w) == i + int'(k)) begin
            l.finished[i] = 1'b1;
         end
      end
      return l;
   endfunction

   assign k_len_ok  = (bus.k_len != '0) && (bus.k_len <= KL_W'(K_MAX));
   // Lanes that are idle or only finishing place no demand on readiness.
   assign accept    = &(~lanes_q.waiting | (bus.a_ready & bus.b_ready));
   assign last_wave = (w_q == (W_W'(k_q) + W_W'(N - 1)));

   // Next-state, wave, drain and stall bookkeeping.
   always_comb begin
      // NOTE: every _d gets a hold/default value first, so no path through
      // the case statement can leave a signal unassigned and infer a latch.
      state_d     = state_q;
      w_d         = w_q;
      k_d         = k_q;
      drain_d     = drain_q;
      stall_d     = stall_q;
      lanes_d     = lanes_q;
      start_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (k_len_ok) begin
                  state_d = ST_FEED;
                  k_d     = bus.k_len;
                  w_d     = '0;
                  stall_d = '0;
                  lanes_d = wave_lanes('0, bus.k_len);
               end else begin
                  start_err_d = 1'b1;
               end
            end
         end

         ST_FEED: begin
            if (accept) begin
               if (last_wave) begin
                  state_d = ST_DRAIN;
                  drain_d = DC_W'(DRAIN_CYC);
                  lanes_d = '0;
               end else begin
                  w_d     = w_q + 1'b1;
                  lanes_d = wave_lanes(w_q + 1'b1, k_q);
               end
            end else if (stall_q != 16'hFFFF) begin
               stall_d = stall_q + 16'd1;
            end
         end

         ST_DRAIN: begin
            if (drain_q <= DC_W'(1)) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            lanes_d = '0;
         end
      endcase

      busy_d = (state_d == ST_FEED) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   // State registers with synchronous reset that abandons any schedule.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples its _d from the
      // same edge, independent of statement order.
      if (rst) begin
         state_q     <= ST_IDLE;
         w_q         <= '0;
         k_q         <= '0;
         drain_q     <= '0;
         stall_q     <= '0;
         lanes_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         k_q         <= k_d;
         drain_q     <= drain_d;
         stall_q     <= stall_d;
         lanes_q     <= lanes_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         start_err_q <= start_err_d;
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.start_err     = start_err_q;
   assign bus.lane_waiting  = lanes_q.waiting;
   assign bus.lane_finished = lanes_q.finished;
   assign bus.lane_idx      = lanes_q.idx;
   assign bus.stall_cnt     = stall_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl. A wave-level reference model
// derives each cycle's expected lane outputs from the skew rule, decides
// acceptance from the readiness it applied, and predicts drain and done.
module tb_systolic_seq_ctrl;
   localparam int N         = 4;
   localparam int K_MAX     = 16;
   localparam int DRAIN_CYC = 8;
   localparam int IDX_W     = $clog2(K_MAX);
   localparam int KL_W      = $clog2(K_MAX + 1);

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   systolic_seq_ctrl_if #(.N(N), .K_MAX(K_MAX)) bus ();

   systolic_seq_ctrl #(.N(N), .K_MAX(K_MAX), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Wave w of a length-k schedule: lane i works on element w-i.
   function automatic void exp_lanes(input int w, input int k,
                                     output logic [N-1:0] wt,
                                     output logic [N-1:0] fin,
                                     output logic [N*IDX_W-1:0] idx);
      wt  = '0;
      fin = '0;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         int e;
         e = w - i;
         if (e >= 0 && e < k) begin
            wt[i]                  = 1'b1;
            idx[i*IDX_W +: IDX_W]  = IDX_W'(e);
         end else if (e == k) begin
            fin[i] = 1'b1;
         end
      end
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_busy"},     32'(bus.busy), 32'd0);
      check({tag, "_done"},     32'(bus.done), 32'd0);
      check({tag, "_waiting"},  32'(bus.lane_waiting), 32'd0);
      check({tag, "_finished"}, 32'(bus.lane_finished), 32'd0);
      check({tag, "_idx"},      32'(bus.lane_idx), 32'd0);
   endtask

   // One full schedule. mode 0: random readiness with stall_pct drop rate;
   // mode 1: a_ready[1]=0 in cycles 3-5; mode 2: b_ready[3]=0 during waves 0-2.
   // inject issues a second start during FEED, which must be ignored.
   task automatic run(input int k, input int mode, input int stall_pct, input bit inject);
      int w, stalls, cyc;
      logic [N-1:0] ew, ef, ra, rb;
      logic [N*IDX_W-1:0] ei;
      bit acc;

      @(negedge clk);
      bus.start = 1'b1;
      bus.k_len = KL_W'(k);
      @(negedge clk);
      bus.start = 1'b0;
      w = 0; stalls = 0; cyc = 1;

      while (w < k + N) begin
         if (cyc > 3000) begin
            check("feed_timeout", 32'(cyc), 32'd3000);
            return;
         end
         exp_lanes(w, k, ew, ef, ei);
         check("waiting",  32'(bus.lane_waiting),  32'(ew));
         check("finished", 32'(bus.lane_finished), 32'(ef));
         check("idx",      32'(bus.lane_idx),      32'(ei));
         check("busy",     32'(bus.busy),          32'd1);
         check("done_early", 32'(bus.done),        32'd0);
         check("stall_cnt_run", 32'(bus.stall_cnt), 32'(stalls));

         ra = '1; rb = '1;
         for (int i = 0; i < N; i++) begin
            if (mode == 0) begin
               ra[i] = ($urandom_range(99) >= stall_pct);
               rb[i] = ($urandom_range(99) >= stall_pct);
            end
         end
         if (mode == 1 && cyc >= 3 && cyc <= 5) ra[1] = 1'b0;
         if (mode == 2 && w <= 2)               rb[3] = 1'b0;
         bus.a_ready = ra;
         bus.b_ready = rb;
         bus.start   = inject && (cyc == 2);
         bus.k_len   = inject ? KL_W'(K_MAX) : KL_W'(k);

         acc = &(~ew | (ra & rb));
         if (acc) w++;
         else     stalls++;

         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
      end

      for (int d = 0; d < DRAIN_CYC; d++) begin
         check("drain_busy",    32'(bus.busy),          32'd1);
         check("drain_done",    32'(bus.done),          32'd0);
         check("drain_waiting", 32'(bus.lane_waiting),  32'd0);
         check("drain_finish",  32'(bus.lane_finished), 32'd0);
         @(negedge clk);
      end
      check("done_pulse", 32'(bus.done),      32'd1);
      check("done_busy",  32'(bus.busy),      32'd0);
      check("stall_cnt",  32'(bus.stall_cnt), 32'(stalls));
      @(negedge clk);
      check("done_after", 32'(bus.done),      32'd0);
      check("idle_busy",  32'(bus.busy),      32'd0);
      bus.a_ready = '1;
      bus.b_ready = '1;
   endtask

   task automatic bad_start(input int k);
      @(negedge clk);
      bus.start = 1'b1;
      bus.k_len = KL_W'(k);
      @(negedge clk);
      bus.start = 1'b0;
      check("start_err_pulse", 32'(bus.start_err), 32'd1);
      check_quiet("bad_start");
      @(negedge clk);
      check("start_err_clear", 32'(bus.start_err), 32'd0);
      check_quiet("bad_start_after");
   endtask

   task automatic reset_mid_run();
      bit saw_done;
      @(negedge clk);
      bus.start = 1'b1;
      bus.k_len = KL_W'(3);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_quiet("mid_rst");
      check("mid_rst_stall", 32'(bus.stall_cnt), 32'd0);
      check("mid_rst_err",   32'(bus.start_err), 32'd0);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      check("rst_no_done", 32'(saw_done), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.k_len   = '0;
      bus.a_ready = '1;
      bus.b_ready = '1;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      check("reset_stall", 32'(bus.stall_cnt), 32'd0);
      check("reset_err",   32'(bus.start_err), 32'd0);
      rst = 1'b0;

      run(3, 0, 0, 1'b0);
      run(3, 1, 0, 1'b0);
      run(3, 2, 0, 1'b0);
      run(1, 0, 0, 1'b0);
      run(K_MAX, 0, 0, 1'b0);
      bad_start(0);
      bad_start(17);
      reset_mid_run();
      run(3, 0, 0, 1'b1);
      for (int r = 0; r < 8; r++) begin
         run(int'($urandom_range(K_MAX, 1)), 0, int'($urandom_range(8, 0)),
             bit'($urandom_range(1, 0)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
